// File: rtl/kgp_risc_pkg.sv
// Shared encodings for the KGP-RISC control path: opcode classes, ALU controls,
// branch fCodes, datapath mux selects and the main FSM state set.
package kgp_risc_pkg;

    localparam logic [4:0] RA_IDX = 5'd31;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_IMM   = 6'd1;
    localparam logic [5:0] OP_SHIFT = 6'd2;
    localparam logic [5:0] OP_LW    = 6'd3;
    localparam logic [5:0] OP_SW    = 6'd4;
    localparam logic [5:0] OP_BR    = 6'd5;
    localparam logic [5:0] OP_FBR   = 6'd6;
    localparam logic [5:0] OP_HALT  = 6'd7;

    localparam logic [2:0] ALU_MEM   = 3'b000;
    localparam logic [2:0] ALU_RTYPE = 3'b001;
    localparam logic [2:0] ALU_IMM   = 3'b010;
    localparam logic [2:0] ALU_SHIFT = 3'b011;
    localparam logic [2:0] ALU_BR    = 3'b100;
    localparam logic [2:0] ALU_FBR   = 3'b101;

    localparam logic [3:0] FC_B    = 4'b0000;
    localparam logic [3:0] FC_BLTZ = 4'b0001;
    localparam logic [3:0] FC_BZ   = 4'b0010;
    localparam logic [3:0] FC_BNZ  = 4'b0011;
    localparam logic [3:0] FC_BL   = 4'b0100;
    localparam logic [3:0] FC_BCY  = 4'b0101;
    localparam logic [3:0] FC_BNCY = 4'b0110;

    localparam logic [1:0] PC_SRC_INC = 2'b00;
    localparam logic [1:0] PC_SRC_REL = 2'b01;
    localparam logic [1:0] PC_SRC_REG = 2'b10;

    localparam logic [1:0] WB_SRC_ALU  = 2'b00;
    localparam logic [1:0] WB_SRC_MEM  = 2'b01;
    localparam logic [1:0] WB_SRC_LINK = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WB, ST_HALT, ST_ERROR
    } state_e;

    function automatic logic [2:0] class_aluop(input logic [5:0] op);
        case (op)
            OP_RTYPE: return ALU_RTYPE;
            OP_IMM:   return ALU_IMM;
            OP_SHIFT: return ALU_SHIFT;
            OP_BR:    return ALU_BR;
            OP_FBR:   return ALU_FBR;
            default:  return ALU_MEM;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Flag-branch condition evaluator: decides taken/illegal from fCode and the
// ALU flags left behind by the previous instruction.
module branch_cond_eval
    import kgp_risc_pkg::*;
(
    input  logic [3:0] fcode,
    input  logic       flag_zero,
    input  logic       flag_sign,
    input  logic       flag_carry,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (fcode)
            FC_B, FC_BL: taken = 1'b1;
            FC_BLTZ:     taken = flag_sign;
            FC_BZ:       taken = flag_zero;
            FC_BNZ:      taken = !flag_zero;
            FC_BCY:      taken = flag_carry;
            FC_BNCY:     taken = !flag_carry;
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// KGP-RISC multi-cycle main control: FETCH/DECODE/EXECUTE/MEM/WB sequencing,
// memory req/ack handshake with timeout, branch resolution and write enables.
module multicycle_ctrl_fsm
    import kgp_risc_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [3:0] fcode_in,
    input  logic       flag_zero,
    input  logic       flag_sign,
    input  logic       flag_carry,
    input  logic       mem_ack,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [2:0] ALUOp,
    output logic [3:0] fCode,
    output logic       reg_write,
    output logic [1:0] wb_src,
    output logic       wb_dst_ra,
    output logic       halted,
    output logic       err
);

    localparam int TW = $clog2(FETCH_TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [5:0]    op_q, op_d;
    logic [3:0]    fc_q, fc_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic       imem_req_q, imem_req_d;
    logic       dmem_req_q, dmem_req_d;
    logic       dmem_we_q, dmem_we_d;
    logic       pc_write_q, pc_write_d;
    logic [1:0] pc_src_q, pc_src_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic [3:0] fcode_q, fcode_d;
    logic       reg_write_q, reg_write_d;
    logic [1:0] wb_src_q, wb_src_d;
    logic       wb_dst_ra_q, wb_dst_ra_d;
    logic       halted_q, halted_d;
    logic       err_q, err_d;

    logic br_taken, br_illegal;
    logic fetch_ack, mem_done, tmo_last;

    branch_cond_eval u_bce (
        .fcode      (fcode_in),
        .flag_zero  (flag_zero),
        .flag_sign  (flag_sign),
        .flag_carry (flag_carry),
        .taken      (br_taken),
        .illegal    (br_illegal)
    );

    // Acks only count while our own request flop is up, so a stale ack that
    // straddles a reset cannot complete a fetch the FSM never issued.
    assign fetch_ack = (state_q == ST_FETCH) && imem_req_q && mem_ack;
    assign mem_done  = (state_q == ST_MEM) && dmem_req_q && mem_ack;
    assign tmo_last  = (tmo_q == TW'(FETCH_TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        fc_d        = fc_q;
        pc_write_d  = 1'b0;
        pc_src_d    = PC_SRC_INC;
        alu_op_d    = ALU_MEM;
        fcode_d     = '0;
        reg_write_d = 1'b0;
        wb_src_d    = WB_SRC_ALU;
        wb_dst_ra_d = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (fetch_ack)     state_d = ST_DECODE;
                else if (tmo_last) state_d = ST_ERROR;
            end
            ST_DECODE: begin
                op_d = opcode;
                fc_d = fcode_in;
                if (opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (opcode > OP_HALT || (opcode == OP_FBR && br_illegal)) begin
                    state_d = ST_ERROR;
                end else begin
                    // EXECUTE strobes are decided here; flags are stable since the
                    // previous instruction's EXECUTE edge.
                    state_d  = ST_EXECUTE;
                    alu_op_d = class_aluop(opcode);
                    fcode_d  = fcode_in;
                    if (opcode == OP_BR) begin
                        pc_write_d = 1'b1;
                        pc_src_d   = PC_SRC_REG;
                    end
                    if (opcode == OP_FBR && br_taken) begin
                        pc_write_d = 1'b1;
                        pc_src_d   = PC_SRC_REL;
                    end
                    if (opcode == OP_FBR && fcode_in == FC_BL) begin
                        reg_write_d = 1'b1;
                        wb_src_d    = WB_SRC_LINK;
                        wb_dst_ra_d = 1'b1;
                    end
                end
            end
            ST_EXECUTE: begin
                case (op_q)
                    OP_LW, OP_SW:  state_d = ST_MEM;
                    OP_BR, OP_FBR: state_d = ST_FETCH;
                    default:       state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_done)      state_d = (op_q == OP_LW) ? ST_WB : ST_FETCH;
                else if (tmo_last) state_d = ST_ERROR;
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = state_q;
        endcase

        if (state_d == ST_WB) begin
            reg_write_d = 1'b1;
            wb_src_d    = (op_d == OP_LW) ? WB_SRC_MEM : WB_SRC_ALU;
        end
        imem_req_d = (state_d == ST_FETCH);
        dmem_req_d = (state_d == ST_MEM);
        dmem_we_d  = (state_d == ST_MEM) && (op_d == OP_SW);
        halted_d   = (state_d == ST_HALT);
        err_d      = (state_d == ST_ERROR);

        if (state_d != state_q)                 tmo_d = '0;
        else if (tmo_q != TW'(FETCH_TIMEOUT))   tmo_d = tmo_q + 1'b1;
        else                                    tmo_d = tmo_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_FETCH;
            op_q        <= '0;
            fc_q        <= '0;
            tmo_q       <= '0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            pc_write_q  <= 1'b0;
            pc_src_q    <= '0;
            alu_op_q    <= '0;
            fcode_q     <= '0;
            reg_write_q <= 1'b0;
            wb_src_q    <= '0;
            wb_dst_ra_q <= 1'b0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            fc_q        <= fc_d;
            tmo_q       <= tmo_d;
            imem_req_q  <= imem_req_d;
            dmem_req_q  <= dmem_req_d;
            dmem_we_q   <= dmem_we_d;
            pc_write_q  <= pc_write_d;
            pc_src_q    <= pc_src_d;
            alu_op_q    <= alu_op_d;
            fcode_q     <= fcode_d;
            reg_write_q <= reg_write_d;
            wb_src_q    <= wb_src_d;
            wb_dst_ra_q <= wb_dst_ra_d;
            halted_q    <= halted_d;
            err_q       <= err_d;
        end
    end

    // IR/PC must capture on the ack edge itself so DECODE already sees the new word.
    assign ir_write  = fetch_ack;
    assign pc_write  = pc_write_q | fetch_ack;
    assign imem_req  = imem_req_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign pc_src    = pc_src_q;
    assign ALUOp     = alu_op_q;
    assign fCode     = fcode_q;
    assign reg_write = reg_write_q;
    assign wb_src    = wb_src_q;
    assign wb_dst_ra = wb_dst_ra_q;
    assign halted    = halted_q;
    assign err       = err_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm: a per-instruction model expands each
// instruction into its expected cycle-by-cycle output vectors.
module tb_multicycle_ctrl_fsm;

    localparam int FT = 16;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [2:0] aluop;
        logic [3:0] fcode;
        logic       reg_write;
        logic [1:0] wb_src;
        logic       wb_dst_ra;
        logic       halted;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [3:0] fcode_in = '0;
    logic       flag_zero = 1'b0, flag_sign = 1'b0, flag_carry = 1'b0;
    logic       mem_ack = 1'b0;
    logic       imem_req, dmem_req, dmem_we, ir_write, pc_write;
    logic [1:0] pc_src, wb_src;
    logic [2:0] ALUOp;
    logic [3:0] fCode;
    logic       reg_write, wb_dst_ra, halted, err;

    vec_t act, exp_v;
    bit   chk_en = 1'b0;
    int   checks = 0, errs = 0;
    int   cyc_n = 0, alu_n = 0, dmem_n = 0, we_n = 0, rw_n = 0, pcw_n = 0, halt_n = 0, imem_n = 0;
    int   s_cyc, s_alu, s_dmem, s_we, s_rw, s_pcw, s_halt, s_imem;

    // ALUOp per opcode class 0..7
    logic [2:0] alu_tbl [0:7] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd4, 3'd5, 3'd0};

    always #5 clk = ~clk;

    assign act = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, ALUOp, fCode,
                  reg_write, wb_src, wb_dst_ra, halted, err};

    multicycle_ctrl_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .fcode_in(fcode_in),
        .flag_zero(flag_zero), .flag_sign(flag_sign), .flag_carry(flag_carry),
        .mem_ack(mem_ack), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .ALUOp(ALUOp),
        .fCode(fCode), .reg_write(reg_write), .wb_src(wb_src), .wb_dst_ra(wb_dst_ra),
        .halted(halted), .err(err)
    );

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (act !== exp_v) begin
                errs++;
                $display("FAIL outputs t=%0t actual=%b required=%b", $time, act, exp_v);
            end
            cyc_n++;
            if (ALUOp != 3'd0) alu_n++;
            if (dmem_req)      dmem_n++;
            if (dmem_we)       we_n++;
            if (reg_write)     rw_n++;
            if (pc_write)      pcw_n++;
            if (halted)        halt_n++;
            if (imem_req)      imem_n++;
        end
    end

    task automatic chk(input string name, input int a, input int e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s actual=%0d required=%0d", name, a, e);
        end
    endtask

    task automatic snap();
        s_cyc = cyc_n; s_alu = alu_n; s_dmem = dmem_n; s_we = we_n;
        s_rw = rw_n; s_pcw = pcw_n; s_halt = halt_n; s_imem = imem_n;
    endtask

    // One clock of stimulus; the compare process checks e at the following negedge.
    task automatic step(input logic ack, input vec_t e);
        mem_ack = ack;
        exp_v   = e;
        chk_en  = 1'b1;
        @(posedge clk);
        #1;
        opcode   = 6'($urandom);
        fcode_in = 4'($urandom);
    endtask

    task automatic reset_now(input string name);
        chk_en  = 1'b0;
        rst     = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk(name, int'(act), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic absorb(input bit is_err, input int n);
        vec_t e;
        e = '0;
        e.err    = is_err;
        e.halted = !is_err;
        repeat (n) step(1'($urandom), e);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [3:0] fc, input logic [2:0] zsc,
                             input int fw, input int mw, input bit first, output bit dead);
        vec_t     e;
        int       miss;
        bit [6:0] conds;
        dead = 1'b0;
        {flag_zero, flag_sign, flag_carry} = zsc;
        conds = {!zsc[0], zsc[0], 1'b1, !zsc[2], zsc[2], zsc[1], 1'b1};
        miss = 0;
        if (first) begin
            e = '0;
            step(1'b1, e);
            miss = 1;
        end
        e = '0;
        e.imem_req = 1'b1;
        for (int i = 0; i < fw; i++) begin
            step(1'b0, e);
            miss++;
            if (miss == FT) begin
                absorb(1'b1, 4);
                dead = 1'b1;
                return;
            end
        end
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        step(1'b1, e);
        e = '0;
        opcode   = op;
        fcode_in = fc;
        step(1'($urandom), e);
        if (op == 6'd7) begin
            absorb(1'b0, 100);
            dead = 1'b1;
            return;
        end
        if (op > 6'd7 || (op == 6'd6 && fc > 4'd6)) begin
            absorb(1'b1, 4);
            dead = 1'b1;
            return;
        end
        e = '0;
        e.aluop = alu_tbl[op[2:0]];
        e.fcode = fc;
        if (op == 6'd5) begin
            e.pc_write = 1'b1;
            e.pc_src   = 2'b10;
        end
        if (op == 6'd6 && conds[fc[2:0]]) begin
            e.pc_write = 1'b1;
            e.pc_src   = 2'b01;
        end
        if (op == 6'd6 && fc == 4'd4) begin
            e.reg_write = 1'b1;
            e.wb_src    = 2'b10;
            e.wb_dst_ra = 1'b1;
        end
        step(1'($urandom), e);
        if (op == 6'd5 || op == 6'd6) return;
        if (op == 6'd3 || op == 6'd4) begin
            e = '0;
            e.dmem_req = 1'b1;
            e.dmem_we  = (op == 6'd4);
            miss = 0;
            for (int i = 0; i < mw; i++) begin
                step(1'b0, e);
                miss++;
                if (miss == FT) begin
                    absorb(1'b1, 4);
                    dead = 1'b1;
                    return;
                end
            end
            step(1'b1, e);
            if (op == 6'd4) return;
        end
        e = '0;
        e.reg_write = 1'b1;
        e.wb_src    = (op == 6'd3) ? 2'b01 : 2'b00;
        step(1'($urandom), e);
    endtask

    initial begin
        bit   dead, first;
        vec_t e;
        int   r;
        logic [5:0] op;
        logic [3:0] fc;
        int   fw, mw;

        reset_now("reset_outs");

        // R-type add, ack on the 2nd cycle after release
        snap();
        run_instr(6'd0, 4'b0010, 3'b000, 0, 0, 1'b1, dead);
        chk("rtype_cycles", cyc_n - s_cyc, 5);
        chk("rtype_alu_cycles", alu_n - s_alu, 1);
        chk("rtype_regwrite", rw_n - s_rw, 1);

        snap();
        run_instr(6'd3, 4'd0, 3'b000, 0, 3, 1'b0, dead);
        chk("lw_dmem_cycles", dmem_n - s_dmem, 4);
        chk("lw_we_cycles", we_n - s_we, 0);
        chk("lw_regwrite", rw_n - s_rw, 1);

        snap();
        run_instr(6'd4, 4'd0, 3'b000, 1, 1, 1'b0, dead);
        chk("sw_we_cycles", we_n - s_we, 2);
        chk("sw_regwrite", rw_n - s_rw, 0);

        snap();
        run_instr(6'd6, 4'd2, 3'b100, 0, 0, 1'b0, dead);
        chk("bz_taken_pcw", pcw_n - s_pcw, 2);
        snap();
        run_instr(6'd6, 4'd2, 3'b011, 0, 0, 1'b0, dead);
        chk("bz_not_taken_pcw", pcw_n - s_pcw, 1);
        snap();
        run_instr(6'd6, 4'd4, 3'b000, 2, 0, 1'b0, dead);
        chk("bl_regwrite", rw_n - s_rw, 1);
        run_instr(6'd5, 4'd9, 3'b111, 0, 0, 1'b0, dead);

        run_instr(6'd6, 4'd7, 3'b000, 0, 0, 1'b0, dead);
        chk("fbr_illegal_dead", dead, 1);
        reset_now("reset_after_illegal_fc");
        run_instr(6'd9, 4'd0, 3'b000, 0, 0, 1'b1, dead);
        chk("opcode9_dead", dead, 1);

        reset_now("reset_before_timeout");
        snap();
        run_instr(6'd0, 4'd0, 3'b000, 15, 0, 1'b1, dead);
        chk("fetch_timeout_dead", dead, 1);
        chk("fetch_timeout_req_cycles", imem_n - s_imem, 15);
        chk("fetch_timeout_cycles", cyc_n - s_cyc, 20);

        reset_now("reset_before_halt");
        snap();
        run_instr(6'd7, 4'd0, 3'b000, 0, 0, 1'b1, dead);
        chk("halt_cycles", halt_n - s_halt, 100);
        chk("halt_imem_req", imem_n - s_imem, 1);

        // async reset in the middle of a load's data wait
        reset_now("reset_before_midmem");
        e = '0;
        step(1'b0, e);
        e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        step(1'b1, e);
        e = '0;
        opcode = 6'd3; fcode_in = 4'd5;
        step(1'b0, e);
        e.fcode = 4'd5;
        step(1'b0, e);
        e = '0; e.dmem_req = 1'b1;
        step(1'b0, e);
        #2;
        reset_now("midmem_async_reset");
        run_instr(6'd1, 4'd3, 3'b010, 0, 0, 1'b1, dead);

        // boundary: ack arrives on the 16th wait cycle, no timeout
        run_instr(6'd4, 4'd0, 3'b000, 15, 15, 1'b0, dead);
        chk("ack_at_limit_alive", dead, 0);

        first = 1'b0;
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 39);
            if (r < 35)      op = 6'(r % 7);
            else if (r < 37) op = 6'd7;
            else             op = 6'($urandom_range(8, 63));
            fc = (op == 6'd6) ? 4'($urandom_range(0, 7)) : 4'($urandom);
            r  = $urandom_range(0, 19);
            fw = (r == 0) ? 15 : (r == 1) ? 16 : $urandom_range(0, 3);
            r  = $urandom_range(0, 19);
            mw = (r == 0) ? 15 : (r == 1) ? 16 : $urandom_range(0, 3);
            run_instr(op, fc, 3'($urandom), fw, mw, first, dead);
            first = 1'b0;
            if (dead) begin
                reset_now("reset_random");
                first = 1'b1;
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
